kirsch_amsg_pipe: RTL and testbench

// - Pipelined, parametrised Kirsch compass-edge engine for one 3x3 window per transfer.
// - Computes any one of the 8 Kirsch directions, or all 8 with max/argmax selection.
// - Output is saturated to the pixel range.
// - Sits between the line-buffer/window generator and the edge-map writer.
// - Uses valid/ready handshakes on both sides.

---
 rtl/kirsch_amsg_pipe_if.sv | 37 +++
 rtl/kirsch_amsg_pipe.sv | 168 ++++++++++++++++
 tb/tb_kirsch_amsg_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kirsch_amsg_pipe_if.sv
// Window-in / edge-out handshake bundle for kirsch_amsg_pipe.
// thr and edge_out exist only when KIRSCH_THRESH_EN is defined.
interface kirsch_amsg_pipe_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] p1, p2, p3, p4, p6, p7, p8, p9;
  logic [2:0]       dir_sel;
  logic             max_mode;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] y_out;
  logic [2:0]       dir_out;
`ifdef KIRSCH_THRESH_EN
  logic [PIX_W-1:0] thr;
  logic             edge_out;
`endif

  modport master (
`ifdef KIRSCH_THRESH_EN
    output thr,
    input  edge_out,
`endif
    output in_valid, p1, p2, p3, p4, p6, p7, p8, p9, dir_sel, max_mode, out_ready,
    input  in_ready, out_valid, y_out, dir_out
  );

  modport slave (
`ifdef KIRSCH_THRESH_EN
    input  thr,
    output edge_out,
`endif
    input  in_valid, p1, p2, p3, p4, p6, p7, p8, p9, dir_sel, max_mode, out_ready,
    output in_ready, out_valid, y_out, dir_out
  );
endinterface

// File: rtl/kirsch_amsg_pipe.sv
// 3-stage Kirsch compass-edge engine (single direction or max/argmax over all 8).
// Optional threshold output enabled by defining KIRSCH_THRESH_EN.
module kirsch_amsg_pipe #(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  kirsch_amsg_pipe_if.slave  bus
);
  localparam int INT_W = PIX_W + 5;
  localparam int A_W   = PIX_W + 2;
  localparam int T_W   = PIX_W + 3;

  // R = 8A - 3T evaluated modulo 2^INT_W; the true R always fits, so wrap-around cancels.
  function automatic logic [PIX_W-1:0] sat_resp(input logic [A_W-1:0] a, input logic [T_W-1:0] t);
    logic [INT_W-1:0] r;
    logic [PIX_W-1:0] y;
    r = {a, 3'b000} - ({1'b0, t, 1'b0} + {2'b00, t});
    if (r[INT_W-1]) begin
      y = {PIX_W{1'b0}};
    end else if (|r[INT_W-2:PIX_W]) begin
      y = {PIX_W{1'b1}};
    end else begin
      y = r[PIX_W-1:0];
    end
    return y;
  endfunction

  logic             v1_r, v2_r, v3_r;
  logic             adv1_s, adv2_s, adv3_s;
  logic [PIX_W-1:0] ring_s [8];
  logic [T_W-1:0]   t_s, t1_r;
  logic [A_W-1:0]   a_s [8];
  logic [A_W-1:0]   a1_r [8];
  logic [2:0]       dir1_r, dir2_r, dir_r;
  logic             max1_r, max2_r;
  logic [PIX_W-1:0] sat_s [8];
  logic [PIX_W-1:0] y2_r [8];
  logic [PIX_W-1:0] best_y_s, y_r;
  logic [2:0]       best_d_s;
`ifdef KIRSCH_THRESH_EN
  logic [PIX_W-1:0] thr1_r, thr2_r;
  logic             edge_r;
`endif

  assign adv3_s       = !v3_r | bus.out_ready;
  assign adv2_s       = !v2_r | adv3_s;
  assign adv1_s       = !v1_r | adv2_s;
  assign bus.in_ready = adv1_s;

  // Neighbour ring, total sum and the eight 3-pixel arc sums.
  always_comb begin
    ring_s[0] = bus.p1;
    ring_s[1] = bus.p2;
    ring_s[2] = bus.p3;
    ring_s[3] = bus.p6;
    ring_s[4] = bus.p9;
    ring_s[5] = bus.p8;
    ring_s[6] = bus.p7;
    ring_s[7] = bus.p4;
    t_s = {T_W{1'b0}};
    for (int k = 0; k < 8; k++) begin
      t_s = t_s + T_W'(ring_s[k]);
    end
    for (int d = 0; d < 8; d++) begin
      a_s[d] = A_W'(ring_s[d]) + A_W'(ring_s[3'(d + 1)]) + A_W'(ring_s[3'(d + 2)]);
    end
  end

  // Stage 1: sums plus the window's control fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      t1_r   <= {T_W{1'b0}};
      dir1_r <= 3'd0;
      max1_r <= 1'b0;
      for (int d = 0; d < 8; d++) a1_r[d] <= {A_W{1'b0}};
`ifdef KIRSCH_THRESH_EN
      thr1_r <= {PIX_W{1'b0}};
`endif
    end else if (adv1_s) begin
      v1_r   <= bus.in_valid;
      t1_r   <= t_s;
      dir1_r <= bus.dir_sel;
      max1_r <= bus.max_mode;
      a1_r   <= a_s;
`ifdef KIRSCH_THRESH_EN
      thr1_r <= bus.thr;
`endif
    end
  end

  // Saturated response for every direction.
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      sat_s[d] = sat_resp(a1_r[d], t1_r);
    end
  end

  // Stage 2: eight saturated responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      dir2_r <= 3'd0;
      max2_r <= 1'b0;
      for (int d = 0; d < 8; d++) y2_r[d] <= {PIX_W{1'b0}};
`ifdef KIRSCH_THRESH_EN
      thr2_r <= {PIX_W{1'b0}};
`endif
    end else if (adv2_s) begin
      v2_r   <= v1_r;
      dir2_r <= dir1_r;
      max2_r <= max1_r;
      y2_r   <= sat_s;
`ifdef KIRSCH_THRESH_EN
      thr2_r <= thr1_r;
`endif
    end
  end

  // Strict greater-than keeps the lowest direction on ties.
  always_comb begin
    best_y_s = y2_r[0];
    best_d_s = 3'd0;
    if (max2_r) begin
      for (int d = 1; d < 8; d++) begin
        if (y2_r[d] > best_y_s) begin
          best_y_s = y2_r[d];
          best_d_s = 3'(d);
        end else begin
          best_y_s = best_y_s;
          best_d_s = best_d_s;
        end
      end
    end else begin
      best_y_s = y2_r[dir2_r];
      best_d_s = dir2_r;
    end
  end

  // Stage 3: registered result; data only replaced by a valid window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r   <= 1'b0;
      y_r    <= {PIX_W{1'b0}};
      dir_r  <= 3'd0;
`ifdef KIRSCH_THRESH_EN
      edge_r <= 1'b0;
`endif
    end else if (adv3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        y_r    <= best_y_s;
        dir_r  <= best_d_s;
`ifdef KIRSCH_THRESH_EN
        edge_r <= (best_y_s >= thr2_r);
`endif
      end
    end
  end

  assign bus.out_valid = v3_r;
  assign bus.y_out     = y_r;
  assign bus.dir_out   = dir_r;
`ifdef KIRSCH_THRESH_EN
  assign bus.edge_out  = edge_r;
`endif
endmodule

// File: tb/tb_kirsch_amsg_pipe.sv
// Self-checking bench for kirsch_amsg_pipe: directed table, backpressure,
// mid-flight reset and randomized streaming against a weight-table model.
module tb_kirsch_amsg_pipe;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kirsch_amsg_pipe_if #(.PIX_W(PW)) bus();
  kirsch_amsg_pipe #(.PIX_W(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    int p[10];
    int dir;
    int mm;
    int thr;
    int ey;
    int ed;
    int ee;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Weights derived directly from each neighbour's position relative to direction d.
  function automatic void fill_model(inout vec_t v);
    int ring[8];
    int r, y, best, bd;
    ring = '{v.p[1], v.p[2], v.p[3], v.p[6], v.p[9], v.p[8], v.p[7], v.p[4]};
    best = -1;
    bd = 0;
    for (int dd = 0; dd < 8; dd++) begin
      r = 0;
      for (int k = 0; k < 8; k++)
        r += ring[k] * ((((k - dd + 8) % 8) < 3) ? 5 : -3);
      y = (r < 0) ? 0 : ((r > 255) ? 255 : r);
      if (v.mm != 0) begin
        if (y > best) begin best = y; bd = dd; end
      end else if (dd == v.dir) begin
        best = y; bd = dd;
      end
    end
    v.ey = best;
    v.ed = bd;
    v.ee = (best >= v.thr) ? 1 : 0;
  endfunction

  function automatic void rand_vec(output vec_t v);
    bit ext;
    ext = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 10; i++)
      v.p[i] = ext ? (($urandom_range(0, 1) == 1) ? 255 : 0) : int'($urandom_range(0, 255));
    v.dir = $urandom_range(0, 7);
    v.mm  = $urandom_range(0, 1);
    v.thr = $urandom_range(0, 255);
    fill_model(v);
  endfunction

  function automatic void mk(output vec_t v, input int a1, a2, a3, a4, a5, a6, a7, a8, a9,
                             input int dir, mm, thr, ey, ed, ee);
    v.p = '{0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    v.dir = dir; v.mm = mm; v.thr = thr;
    v.ey = ey; v.ed = ed; v.ee = ee;
  endfunction

  task automatic drive(input vec_t v);
    bus.p1 = PW'(v.p[1]); bus.p2 = PW'(v.p[2]); bus.p3 = PW'(v.p[3]);
    bus.p4 = PW'(v.p[4]); bus.p6 = PW'(v.p[6]);
    bus.p7 = PW'(v.p[7]); bus.p8 = PW'(v.p[8]); bus.p9 = PW'(v.p[9]);
    bus.dir_sel  = 3'(v.dir);
    bus.max_mode = 1'(v.mm);
`ifdef KIRSCH_THRESH_EN
    bus.thr = PW'(v.thr);
`endif
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, "_y"}, int'(bus.y_out), v.ey);
    chk({nm, "_dir"}, int'(bus.dir_out), v.ed);
`ifdef KIRSCH_THRESH_EN
    chk({nm, "_edge"}, int'(bus.edge_out), v.ee);
`endif
  endtask

  // Cycle-driven stream with scoreboard; mode 0 = hold out_ready low 5 cycles, mode 1 = random.
  task automatic stream(input int n, input int mode);
    vec_t cur, exp;
    vec_t sb[$];
    int sent, got, cyc, hy, hd, he;
    bit hold;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; hy = 0; hd = 0; he = 0;
    rand_vec(cur);
    while ((sent < n || sb.size() > 0) && cyc < 2000) begin
      @(posedge clk); #1;
      if (sent < n) begin
        bus.in_valid = 1'b1;
        drive(cur);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (mode == 0) ? (cyc >= 5) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_y", int'(bus.y_out), hy);
        chk("hold_dir", int'(bus.dir_out), hd);
`ifdef KIRSCH_THRESH_EN
        chk("hold_edge", int'(bus.edge_out), he);
`endif
      end
      if (mode == 0 && cyc == 4) begin
        chk("bp_accepts", sent, 3);
        chk("bp_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("stray_output", 1, int'(sb.size()));
        end else begin
          exp = sb.pop_front();
          chk_out("stream", exp);
          got++;
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hy = int'(bus.y_out);
      hd = int'(bus.dir_out);
`ifdef KIRSCH_THRESH_EN
      he = int'(bus.edge_out);
`endif
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(cur);
        sent++;
        rand_vec(cur);
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_sent", sent, n);
    chk("stream_got", got, n);
  endtask

  initial begin
    vec_t z, va, vb;
    int lat;
    bit stale;

    mk(tbl[0], 100, 100, 100, 100, 100, 100, 100, 100, 100, 3, 0, 0, 0, 3, 1);
    mk(tbl[1], 255, 255, 0, 255, 200, 0, 0, 0, 0, 7, 0, 255, 255, 7, 1);
    mk(tbl[2], 255, 255, 0, 255, 200, 0, 0, 0, 0, 3, 0, 1, 0, 3, 0);
    mk(tbl[3], 0, 0, 10, 0, 0, 10, 0, 0, 10, 5, 1, 150, 150, 2, 1);
    mk(tbl[4], 0, 0, 10, 0, 0, 10, 0, 0, 10, 5, 1, 151, 150, 2, 0);
    mk(tbl[5], 255, 255, 255, 255, 255, 255, 255, 255, 255, 5, 1, 1, 0, 0, 0);
    mk(tbl[6], 20, 20, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 255, 0, 1);
    mk(tbl[7], 20, 20, 20, 0, 0, 0, 0, 0, 0, 1, 0, 140, 140, 1, 1);
    mk(tbl[8], 0, 50, 0, 0, 0, 0, 0, 0, 0, 6, 1, 251, 250, 0, 0);

    mk(z, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y", int'(bus.y_out), 0);
    chk("rst_dir", int'(bus.dir_out), 0);
`ifdef KIRSCH_THRESH_EN
    chk("rst_edge", int'(bus.edge_out), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // Directed table, one window at a time, latency measured.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      drive(tbl[i]);
      @(negedge clk);
      chk("tbl_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 10);
      chk($sformatf("tbl%0d_latency", i), lat, 3);
      chk_out($sformatf("tbl%0d", i), tbl[i]);
    end
    @(posedge clk); #1;

    stream(6, 0);

    // Mid-flight reset with a held result at the output.
    rand_vec(va);
    rand_vec(vb);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    drive(va);
    @(posedge clk); #1;
    drive(vb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("prerst_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_y", int'(bus.y_out), 0);
    chk("midrst_dir", int'(bus.dir_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      stale |= bus.out_valid;
    end
    chk("no_stale", int'(stale), 0);
    chk("postrst_in_ready", int'(bus.in_ready), 1);

    stream(300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
